mem_responder: RTL

Backing-memory responder on the downstream side of the cache.
- Serves line refills (reads) and line write-backs (writes) issued by the cache.
- Uses a valid/ready request handshake, beat-wise data transfer and a programmable fixed access latency.
- Doubles as the main-memory model in cache-level benches.

---
 rtl/mem_pkg.sv | 11 +
 rtl/mem_array.sv | 16 +
 rtl/mem_responder.sv | 95 +++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding and default geometry for the backing-memory responder.
package mem_pkg;
    localparam int LINE_WORDS_DEF = 4;
    localparam int DEPTH_WORDS_DEF = 256;
    localparam int LATENCY_DEF = 4;
    localparam int OFFS_W = $clog2(LINE_WORDS_DEF) + 2;
    localparam int IDX_W = $clog2(DEPTH_WORDS_DEF);
    localparam int BEAT_W = $clog2(LINE_WORDS_DEF);
    localparam int LAT_W = $clog2(LATENCY_DEF + 1);
    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_DATA, WR_WAIT, WR_ACK} mem_state_t;
endpackage

// File: rtl/mem_array.sv
// mem_array: word storage with synchronous write and asynchronous read.
module mem_array #(
    parameter int DEPTH = 256,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;
    assign rdata = mem[addr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: line refill/write-back responder with fixed latency; MEM_RANGE_ERR_EN adds out-of-range error reporting.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_last,
    output logic              wr_done,
    output logic              rsp_err
);
    localparam int BW = $clog2(LINE_WORDS);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int OW = BW + 2;
    localparam int LW = IW - BW;
    localparam int CW = $clog2(LATENCY + 1);
    mem_state_t state, nxt;
    logic [LW-1:0] line;
    logic [BW-1:0] beat;
    logic [CW-1:0] cnt;
    logic err, range_err, accept, wr_beat, wait_done, unused;
    logic [DATA_W-1:0] mem_rd;
    assign accept = req_valid && state == IDLE;
    assign wr_beat = state == WR_DATA && wdata_valid;
    assign wait_done = int'(cnt) >= LATENCY - 2;
    assign unused = ^{req_addr[OW-1:0], req_addr[ADDR_W-1:IW+2]};
`ifdef MEM_RANGE_ERR_EN
    assign range_err = |req_addr[ADDR_W-1:IW+2];
`else
    assign range_err = 1'b0;
`endif
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= nxt;
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:     if (accept) nxt = req_wr ? WR_DATA : (LATENCY == 1 ? RD_BURST : RD_WAIT);
            RD_WAIT:  if (wait_done) nxt = RD_BURST;
            RD_BURST: if (rsp_ready && &beat) nxt = IDLE;
            WR_DATA:  if (wdata_valid && &beat) nxt = LATENCY == 1 ? WR_ACK : WR_WAIT;
            WR_WAIT:  if (wait_done) nxt = WR_ACK;
            WR_ACK:   nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end
    always_comb begin
        req_ready = state == IDLE;
        wdata_ready = state == WR_DATA;
        rsp_valid = state == RD_BURST;
        rsp_last = rsp_valid && &beat;
        wr_done = state == WR_ACK;
        rdata = (rsp_valid && !err) ? mem_rd : '0;
`ifdef MEM_RANGE_ERR_EN
        rsp_err = err && (rsp_valid || wr_done);
`else
        rsp_err = 1'b0;
`endif
    end
    // beat wraps to 0 at line end, so every operation starts at word 0
    always_ff @(posedge clk)
        if (rst) begin
            beat <= '0;
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (accept) err <= range_err;
            if ((rsp_valid && rsp_ready) || wr_beat) beat <= beat + 1'b1;
            cnt <= (state == RD_WAIT || state == WR_WAIT) ? cnt + 1'b1 : '0;
        end
    always_ff @(posedge clk)
        if (accept) line <= req_addr[OW +: LW];
    mem_array #(.DEPTH(DEPTH_WORDS), .DATA_W(DATA_W)) u_array (
        .clk(clk),
        .we(wr_beat && !err),
        .addr({line, beat}),
        .wdata(wdata),
        .rdata(mem_rd)
    );
endmodule
